// File: rtl/hash_function.sv
// ============================================================================
// hash_function : iterative 32-bit hash, one mixing round per clock.
// Optional busy output enabled by macro HASH_FUNCTION_BUSY_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module hash_function #(
   parameter int unsigned ROUNDS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] m  [0:3],
   input  logic [7:0] IV [0:3],
   output logic [7:0] d  [0:3],
   output logic       done
`ifdef HASH_FUNCTION_BUSY_EN
   ,
   output logic       busy
`endif
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_RUN   = 1'b1;
   localparam logic [7:0] LAST_RC = 8'(ROUNDS - 1);

   logic [0:0] state_q, state_d;
   logic [7:0] rc_q, rc_d;
   logic [7:0] h_q [0:3];
   logic [7:0] h_d [0:3];
   logic [7:0] m_q [0:3];
   logic [7:0] m_d [0:3];
   logic [7:0] v_q [0:3];
   logic [7:0] v_d [0:3];
   logic [7:0] d_q [0:3];
   logic [7:0] d_d [0:3];
   logic       done_q, done_d;

   logic [7:0] t      [0:3];
   logic [7:0] h_next [0:3];
   logic       last_round;

   assign last_round = (rc_q == LAST_RC);

   // Round function: message byte selection rotates with the round index.
   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign t[i]      = h_q[i] ^ m_q[2'(i) + rc_q[1:0]];
      assign h_next[i] = {t[i][6:0], t[i][7]} + t[(i + 1) % 4] + rc_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rc_q    <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            h_q[i] <= '0;
            m_q[i] <= '0;
            v_q[i] <= '0;
            d_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
         done_q  <= done_d;
         for (int i = 0; i < 4; i++) begin
            h_q[i] <= h_d[i];
            m_q[i] <= m_d[i];
            v_q[i] <= v_d[i];
            d_q[i] <= d_d[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)      state_d = S_RUN;
         S_RUN:   if (last_round) state_d = S_IDLE;
         default:                 state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rc_d   = rc_q;
      done_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         h_d[i] = h_q[i];
         m_d[i] = m_q[i];
         v_d[i] = v_q[i];
         d_d[i] = d_q[i];
      end
      if (state_q == S_IDLE) begin
         if (start) begin
            rc_d = '0;
            for (int i = 0; i < 4; i++) begin
               h_d[i] = IV[i];
               m_d[i] = m[i];
               v_d[i] = IV[i];
            end
         end
      end else if (last_round) begin
         done_d = 1'b1;
         // Feed-forward of the chaining value into the digest.
         for (int i = 0; i < 4; i++) d_d[i] = h_next[i] ^ v_q[i];
      end else begin
         rc_d = rc_q + 8'd1;
         for (int i = 0; i < 4; i++) h_d[i] = h_next[i];
      end
   end

   assign d    = d_q;
   assign done = done_q;

`ifdef HASH_FUNCTION_BUSY_EN
   logic busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      if (state_q == S_IDLE && start)    busy_d = 1'b1;
      else if (state_q == S_RUN && last_round) busy_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= 1'b0;
      else        busy_q <= busy_d;
   end

   assign busy = busy_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hash_function.sv
// ============================================================================
// tb_hash_function : scoreboard-driven self-checking bench for hash_function.
// ============================================================================
`default_nettype none

module tb_hash_function;

   localparam int ROUNDS = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] m  [0:3];
   logic [7:0] IV [0:3];
   logic [7:0] d  [0:3];
   logic       done;
`ifdef HASH_FUNCTION_BUSY_EN
   logic       busy;
`endif

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_d;

   hash_function #(.ROUNDS(ROUNDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .m     (m),
      .IV    (IV),
      .d     (d),
      .done  (done)
`ifdef HASH_FUNCTION_BUSY_EN
      ,
      .busy  (busy)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inputs(input logic [31:0] mm, input logic [31:0] iv);
      for (int i = 0; i < 4; i++) begin
         m[i]  = mm[31 - 8*i -: 8];
         IV[i] = iv[31 - 8*i -: 8];
      end
   endtask

   function automatic logic [31:0] dig();
      return {d[0], d[1], d[2], d[3]};
   endfunction

   // Reference model of the round function and feed-forward.
   function automatic logic [31:0] model(input logic [31:0] mm, input logic [31:0] iv);
      logic [7:0] h [4];
      logic [7:0] mb [4];
      logic [7:0] tt [4];
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         h[i]  = iv[31 - 8*i -: 8];
         mb[i] = mm[31 - 8*i -: 8];
      end
      for (int r = 0; r < ROUNDS; r++) begin
         for (int i = 0; i < 4; i++) tt[i] = h[i] ^ mb[(i + r) % 4];
         for (int i = 0; i < 4; i++)
            h[i] = 8'((tt[i] << 1) | (tt[i] >> 7)) + tt[(i + 1) % 4] + 8'(r + 1);
      end
      for (int i = 0; i < 4; i++) res[31 - 8*i -: 8] = h[i] ^ iv[31 - 8*i -: 8];
      return res;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'($urandom);
      set_inputs($urandom, $urandom);
      repeat (3) tick();
      checks++;
      if (dig() !== 32'h0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: d=%08h done=%b expected d=00000000 done=0", dig(), done);
      end
      start = 1'b0;
      rst_n = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
         checks++;
         if (done !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_done: cycle %0d done=%b expected 0", j, done);
         end
      end
   endtask

   task automatic test_zero_vector();
      exp_q.push_back(32'h3A3A3A3A);
      set_inputs(32'h0, 32'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 1; j <= ROUNDS; j++) begin
         tick();
         checks++;
         if (done !== (j == ROUNDS)) begin
            failures++;
            $display("FAIL zero_latency: cycle %0d done=%b expected %b", j, done, (j == ROUNDS));
         end
      end
      exp_d = exp_q.pop_front();
      checks++;
      if (dig() !== exp_d) begin
         failures++;
         $display("FAIL zero_digest: d=%08h expected %08h", dig(), exp_d);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL zero_done_pulse: done=%b expected 0", done);
      end
   endtask

   task automatic test_known_vector();
      exp_q.push_back(32'h1D8EDE5B);
      set_inputs(32'h01020304, 32'h34550F14);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 1; j < ROUNDS; j++) begin
         tick();
`ifdef HASH_FUNCTION_BUSY_EN
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_run: cycle %0d busy=%b expected 1", j, busy);
         end
`endif
      end
      tick();
      exp_d = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || dig() !== exp_d) begin
         failures++;
         $display("FAIL known_digest: done=%b d=%08h expected done=1 d=%08h", done, dig(), exp_d);
      end
      for (int j = 0; j < 3; j++) begin
         tick();
         checks++;
         if (done !== 1'b0 || dig() !== exp_d) begin
            failures++;
            $display("FAIL known_hold: done=%b d=%08h expected done=0 d=%08h", done, dig(), exp_d);
         end
      end
   endtask

   task automatic test_second_op();
      logic [31:0] old_d;
      old_d = dig();
      exp_q.push_back(32'h3A3A3A3A);
      set_inputs(32'h0, 32'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      set_inputs($urandom, $urandom);
      for (int j = 1; j < ROUNDS; j++) begin
         tick();
         checks++;
         if (done !== 1'b0 || dig() !== old_d) begin
            failures++;
            $display("FAIL second_during_run: cycle %0d done=%b d=%08h expected done=0 d=%08h",
                     j, done, dig(), old_d);
         end
      end
      tick();
      exp_d = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || dig() !== exp_d) begin
         failures++;
         $display("FAIL second_digest: done=%b d=%08h expected done=1 d=%08h", done, dig(), exp_d);
      end
   endtask

   task automatic test_start_during_run();
      logic [31:0] mm, iv;
      int ndone;
      mm = $urandom;
      iv = $urandom;
      exp_q.push_back(model(mm, iv));
      set_inputs(mm, iv);
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      for (int j = 1; j < ROUNDS; j++) begin
         tick();
         start = (j == 1);
         if (j == 1) set_inputs($urandom, $urandom);
         if (done === 1'b1) ndone++;
      end
      start = 1'b0;
      tick();
      exp_d = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || dig() !== exp_d) begin
         failures++;
         $display("FAIL run_start_digest: done=%b d=%08h expected done=1 d=%08h", done, dig(), exp_d);
      end
      for (int j = 0; j < 2 * ROUNDS; j++) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      checks++;
      if (ndone !== 0) begin
         failures++;
         $display("FAIL run_start_ignored: extra done pulses=%0d expected 0", ndone);
      end
   endtask

   task automatic test_reset_mid_run();
      int ndone;
      set_inputs(32'h01020304, 32'h34550F14);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #2;
      checks++;
      if (dig() !== 32'h0 || done !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: d=%08h done=%b expected d=00000000 done=0", dig(), done);
      end
      tick();
      rst_n = 1'b1;
      ndone = 0;
      for (int j = 0; j < 10; j++) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      checks++;
      if (ndone !== 0 || dig() !== 32'h0) begin
         failures++;
         $display("FAIL abort_no_done: done pulses=%0d d=%08h expected 0 and 00000000", ndone, dig());
      end
      exp_q.push_back(32'h1D8EDE5B);
      set_inputs(32'h01020304, 32'h34550F14);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (ROUNDS) tick();
      exp_d = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || dig() !== exp_d) begin
         failures++;
         $display("FAIL post_reset_digest: done=%b d=%08h expected done=1 d=%08h", done, dig(), exp_d);
      end
   endtask

   task automatic test_back_to_back();
      localparam int N = 3;
      logic [31:0] mm, iv;
      tick();
      mm = $urandom;
      iv = $urandom;
      exp_q.push_back(model(mm, iv));
      set_inputs(mm, iv);
      start = 1'b1;
      tick();
      for (int op = 0; op < N; op++) begin
         if (op < N - 1) begin
            mm = $urandom;
            iv = $urandom;
            exp_q.push_back(model(mm, iv));
            set_inputs(mm, iv);
         end else begin
            start = 1'b0;
         end
         for (int j = 1; j < ROUNDS; j++) begin
            tick();
            checks++;
            if (done !== 1'b0) begin
               failures++;
               $display("FAIL b2b_early_done: op %0d cycle %0d done=%b expected 0", op, j, done);
            end
         end
         tick();
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b2b_scoreboard: op %0d queue empty expected one entry", op);
         end else begin
            exp_d = exp_q.pop_front();
            checks++;
            if (done !== 1'b1 || dig() !== exp_d) begin
               failures++;
               $display("FAIL b2b_digest: op %0d done=%b d=%08h expected done=1 d=%08h",
                        op, done, dig(), exp_d);
            end
         end
         tick();
         checks++;
         if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_pulse: op %0d done=%b expected 0", op, done);
         end
      end
      repeat (2 * ROUNDS) tick();
      checks++;
      if (done !== 1'b0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_drain: done=%b pending=%0d expected 0 and 0", done, exp_q.size());
      end
   endtask

   initial begin
      set_inputs(32'h0, 32'h0);
      test_reset();
      test_zero_vector();
      test_known_vector();
      test_second_op();
      test_start_during_run();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
